// File: rtl/circular_adder_pkg.sv
// Shared control definitions for modulo index counters: the default index width
// and a count type for blocks that exchange indices with circular_adder.
package circular_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : circular_adder_pkg

// File: rtl/circular_adder.sv
// Modulo counter cycling 0..max inclusive, with max a run-time input.
// Define CIRCULAR_ADDER_WRAP_FLAG_EN to add a registered `wrap` output.
module circular_adder
    import circular_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] max,
`ifdef CIRCULAR_ADDER_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_out;
    logic             w_at_bound;

    // ">=" rather than "==": a max lowered below the count still wraps at once,
    // and the increment below only happens when it cannot overflow.
    assign w_at_bound = (r_out >= max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (enable) begin
            r_out <= w_at_bound ? '0 : r_out + WIDTH'(1'b1);
        end
    end

    assign out = r_out;

`ifdef CIRCULAR_ADDER_WRAP_FLAG_EN
    logic r_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= enable & w_at_bound;
        end
    end

    assign wrap = r_wrap;
`endif

endmodule : circular_adder

// File: tb/tb_circular_adder.sv
// Self-checking bench for circular_adder: directed test-plan steps followed by
// randomized traffic, all compared against an integer reference model.
module tb_circular_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] max = '0;
    logic [W-1:0] out;
`ifdef CIRCULAR_ADDER_WRAP_FLAG_EN
    logic         wrap;
`endif

    int total = 0;
    int bad   = 0;
    int steps = 0;

    // Reference state: the count as a plain integer, and the expected wrap flag.
    int exp_out  = 0;
    int exp_wrap = 0;

    circular_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .max    (max),
`ifdef CIRCULAR_ADDER_WRAP_FLAG_EN
        .wrap   (wrap),
`endif
        .out    (out)
    );

    always #5 clk = ~clk;

    // Apply inputs for one clock, advance the model, check 1 time unit after the edge.
    task automatic step(input logic r, input logic en, input int mx, input string tag);
        logic [W-1:0] want_out;
        rst    = r;
        enable = en;
        max    = W'(mx);
        @(posedge clk);
        if (r) begin
            exp_out  = 0;
            exp_wrap = 0;
        end else if (en) begin
            exp_wrap = (exp_out >= mx) ? 1 : 0;
            exp_out  = (exp_out >= mx) ? 0 : exp_out + 1;
        end else begin
            exp_wrap = 0;
        end
        #1;
        steps++;
        want_out = W'(exp_out);
        $display("step %0d %s rst=%0b en=%0b max=%0d out=%0d exp=%0d",
                 steps, tag, r, en, mx, out, exp_out);
        total++;
        assert (out === want_out)
        else begin
            bad++;
            $error("FAIL %s out observed=%0d expected=%0d", tag, out, want_out);
        end
`ifdef CIRCULAR_ADDER_WRAP_FLAG_EN
        total++;
        assert (wrap === 1'(exp_wrap))
        else begin
            bad++;
            $error("FAIL %s wrap observed=%0b expected=%0d", tag, wrap, exp_wrap);
        end
`endif
    endtask

    initial begin
        // Reset with enable high: count must not advance.
        step(1, 1, 2, "reset");
        // Free run, max=2: 1,2,0,1,2,0...
        for (int n = 0; n < 30; n++) step(0, 1, 2, "freerun");

        // Enable hold at 3, then resume 4,5,0.
        step(1, 0, 5, "reset");
        for (int n = 0; n < 3; n++) step(0, 1, 5, "count5");
        for (int n = 0; n < 4; n++) step(0, 0, 5, "hold");
        for (int n = 0; n < 3; n++) step(0, 1, 5, "resume");

        // max=0: constant 0 (and wrap high every cycle when present).
        for (int n = 0; n < 5; n++) step(0, 1, 0, "max0");

        // Full range: 0..15 then back to 0.
        step(1, 0, 15, "reset");
        for (int n = 0; n < 18; n++) step(0, 1, 15, "full");

        // Dynamic max: reach 4 under max=7, then drop max to 2.
        step(1, 0, 7, "reset");
        for (int n = 0; n < 4; n++) step(0, 1, 7, "dyn7");
        for (int n = 0; n < 4; n++) step(0, 1, 2, "dyn2");

        // Mid-run reset at out=1 with max=3, then 1,2,3,0.
        step(1, 0, 3, "reset");
        step(0, 1, 3, "pre");
        step(1, 1, 3, "midrst");
        for (int n = 0; n < 5; n++) step(0, 1, 3, "post");

        // Random traffic: occasional reset, random enable and bound.
        for (int n = 0; n < 300; n++) begin
            logic r_bit;
            logic e_bit;
            r_bit = ($urandom_range(15, 0) == 0);
            e_bit = ($urandom_range(3, 0) != 0);
            step(r_bit, e_bit, int'($urandom_range(15, 0)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_circular_adder
